// File: rtl/svcoeff_loader.sv
// Loads the SVM coefficient set from a fixed-latency memory into the classifier
// coefficient chain between frames; a frame start during a load aborts it.
module svcoeff_loader #(
    parameter int CWIDTH   = 9,
    parameter int NCOEFF   = 2048,
    parameter int AWIDTH   = $clog2(NCOEFF),
    parameter int MEM_LAT  = 2,
    parameter int AUTOLOAD = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_fv,
    input  logic                     start,
    output logic                     mem_rd,
    output logic [AWIDTH-1:0]        mem_addr,
    input  logic [CWIDTH-1:0]        mem_rdata,
    output logic signed [CWIDTH-1:0] svcoeff_out,
    output logic                     out_cv,
    output logic                     busy,
    output logic                     done,
    output logic                     loaded,
    output logic                     abort_err,
    output logic                     overrun
);

    localparam int DCW = $clog2(MEM_LAT + 2);
    localparam logic [AWIDTH-1:0] LAST_ADDR  = AWIDTH'(NCOEFF - 1);
    localparam logic [DCW-1:0]    DRAIN_LAST = DCW'(MEM_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   addr_q;
    logic [DCW-1:0]      drain_q;
    logic [MEM_LAT-1:0]  vsr_q;
    logic                armed_q;
    logic                autoload_pend_q;
    logic                accept;
    logic                abort;
    logic                enter_read;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: every sequential block uses <= so all registers update from
            // the same pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    // NOTE: every variable below gets a default first, so no path through the
    // case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        abort   = 1'b0;
        mem_rd  = (state_q == S_READ);
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (start || autoload_pend_q) begin
                    accept  = 1'b1;
                    state_d = in_fv ? S_WAIT : S_READ;
                end
            end
            S_WAIT: begin
                if (!in_fv) state_d = S_READ;
            end
            S_READ: begin
                if (in_fv) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (in_fv) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end else if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_read = (state_d == S_READ) && (state_q != S_READ);
    assign mem_addr   = addr_q;

    // Address and drain counters; the address saturates at the last coefficient.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            drain_q <= '0;
        end else begin
            if (enter_read) begin
                addr_q <= '0;
            end else if (state_q == S_READ && addr_q != LAST_ADDR) begin
                addr_q <= addr_q + 1'b1;
            end
            if (state_q != S_DRAIN) begin
                drain_q <= '0;
            end else begin
                drain_q <= drain_q + 1'b1;
            end
        end
    end

    // NOTE: the valid pipeline is reset (and flushed on abort) because a stale
    // bit would emit a coefficient nobody requested.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsr_q       <= '0;
            svcoeff_out <= '0;
            out_cv      <= 1'b0;
        end else begin
            if (abort) begin
                vsr_q <= '0;
            end else begin
                vsr_q[0] <= mem_rd;
                for (int i = 1; i < MEM_LAT; i++) begin
                    vsr_q[i] <= vsr_q[i-1];
                end
            end
            if (vsr_q[MEM_LAT-1] && !abort) begin
                svcoeff_out <= mem_rdata;
                out_cv      <= 1'b1;
            end else begin
                out_cv <= 1'b0;
            end
        end
    end

    // Status flags; the first clock after reset release arms the autoload request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_q         <= 1'b0;
            autoload_pend_q <= 1'b0;
            loaded          <= 1'b0;
            abort_err       <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            if (accept) begin
                autoload_pend_q <= 1'b0;
            end else if (!armed_q) begin
                autoload_pend_q <= (AUTOLOAD != 0);
            end

            if (accept || abort) begin
                loaded <= 1'b0;
            end else if (state_d == S_DONE) begin
                loaded <= 1'b1;
            end

            if (accept) begin
                abort_err <= 1'b0;
            end else if (abort) begin
                abort_err <= 1'b1;
            end

            if (accept) begin
                overrun <= 1'b0;
            end else if (start && busy) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: doc/svcoeff_loader.md
# svcoeff_loader

Sequencer that loads the SVM coefficient set into the sliding-window classifier's coefficient chain between frames. It reads `NCOEFF` coefficients from a fixed-latency coefficient memory. It streams them in address order on `svcoeff_out`/`out_cv` into the classifier's `svcoeff_in`/`in_cv`. Loads run only while the frame-valid input is low, and a frame start during a load aborts it cleanly.

## Interface
- `CWIDTH`, 9, coefficient width (signed, two's complement).
- `NCOEFF`, 2048, coefficients per load (BLOCKSIZE·WINCOLS·WINROWS = 16·8·16); must be ≥2.
- `AWIDTH`, `$clog2(NCOEFF)`, memory address width.
- `MEM_LAT`, 2, coefficient memory read latency in cycles; must be ≥1.
- `AUTOLOAD`, 1, 1 = request one load automatically after reset release.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_fv` in 1: frame valid; high while a frame's pixels flow.
- `start` in 1: one-cycle load request.
- `mem_rd` out 1: memory read strobe.
- `mem_addr` out AWIDTH: read address.
- `mem_rdata` in CWIDTH: read data, valid exactly MEM_LAT cycles after the `mem_rd` cycle.
- `svcoeff_out` out CWIDTH signed: coefficient to the classifier chain.
- `out_cv` out 1: coefficient valid.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse when a load completes.
- `loaded` out 1: a complete coefficient set has been delivered since the last abort or reset.
- `abort_err` out 1: sticky; a load was aborted by `in_fv`.
- `overrun` out 1: sticky; `start` arrived while busy.

## Operation
- States:
  - IDLE: entered on reset.
  - WAIT: a request is pending and `in_fv` is high.
  - READ: reads are issued.
  - DRAIN: outstanding reads finish.
  - DONE: completion cycle.
- IDLE:
  - With `start`=1 or a pending autoload, go to READ if `in_fv`=0, otherwise to WAIT.
  - Autoload is pending from reset release until the first transition out of IDLE.
- WAIT → READ on the first cycle `in_fv`=0.
- READ:
  - `mem_rd`=1 every cycle. `mem_addr` runs 0..NCOEFF-1, one per cycle, no gaps.
  - After address NCOEFF-1 is issued, go to DRAIN.
- DRAIN:
  - Lasts MEM_LAT+1 cycles, so the last coefficient leaves on `out_cv`.
  - Then go to DONE for one cycle (`done`=1), then IDLE.
- Output path:
  - A MEM_LAT-deep valid shift register tracks `mem_rd`.
  - When the delayed valid is 1, `svcoeff_out` ← `mem_rdata` (registered) and `out_cv` ← 1 in the next cycle.
  - Otherwise `out_cv`=0 and `svcoeff_out` holds its last value.
- Abort:
  - Triggered when `in_fv` rises while the FSM is in READ or DRAIN.
  - Next state is IDLE. The valid shift register is cleared, so no `out_cv` is asserted from the next cycle on.
  - `abort_err` is set, `loaded` is cleared, and `done` is not asserted.
  - No automatic retry; software must re-issue `start`.
- `start` while busy is ignored and sets `overrun`.
- `abort_err` and `overrun` clear on the next accepted `start` (IDLE→WAIT/READ).
- `loaded`: cleared when a load is accepted, set in DONE.
- Address counter: AWIDTH bits, reset to 0 at each READ entry, never wraps mid-load.

## Timing
- Reset values: every output is 0, including `svcoeff_out`, `mem_addr` and `loaded`. FSM in IDLE; autoload pending if AUTOLOAD=1.
- Accept latency: `start` at cycle t with `in_fv`=0 gives the first `mem_rd` at t+1.
- Read window: `mem_rd` is high for cycles t+1..t+NCOEFF.
- Output window: `out_cv` is high for cycles t+MEM_LAT+2..t+NCOEFF+MEM_LAT+1, contiguous, with coefficient k at t+MEM_LAT+2+k.
- Completion: `done` pulses and `loaded` rises at t+NCOEFF+MEM_LAT+2. `busy` falls at t+NCOEFF+MEM_LAT+3.
- Autoload: after reset deassertion, the first `mem_rd` is 2 cycles later if `in_fv`=0.
- `in_fv` and `start` in the same IDLE cycle: go to WAIT.
- `in_fv` falling edge in WAIT: `mem_rd` is asserted the next cycle.
- Reset mid-load: everything returns to reset values immediately (asynchronous). The FSM restarts in IDLE, and autoload applies again.

## Test plan
- NCOEFF=8, MEM_LAT=2, AUTOLOAD=0, memory holding 10·addr−40 (signed), `start` at cycle 10 with `in_fv`=0:
  - `mem_addr` 0..7 at cycles 11–18.
  - `out_cv` at cycles 14–21 with values −40,−30,…,30.
  - `done` at 22; `loaded`=1.
- `start` while `in_fv`=1, then `in_fv` falls at cycle 30 → `busy`=1 during the wait, first `mem_rd` at 31.
- `in_fv` rises during READ after 3 addresses → IDLE next cycle, at most 0 further `out_cv`, `abort_err`=1, `loaded`=0, no `done`.
- `start` pulsed mid-READ → `overrun`=1. The load completes unchanged with exactly 8 `out_cv` cycles. The next accepted `start` clears `overrun`.
- AUTOLOAD=1, `in_fv`=0 at reset release → full load without `start`; `loaded`=1 at release+2+NCOEFF+MEM_LAT+1.
- `reset_n` low mid-DRAIN → all outputs 0 asynchronously; after release with AUTOLOAD=1, a fresh load starts from address 0.
